// File: rtl/multiword_add_seq.sv
// Multi-word adder sequencer: streams WORDS slices of N bits through one
// ripple-carry adder, chaining the carry between slices through a register.

module rca #(
   parameter int N = 8
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic [N-1:0] Sum,
   output logic         Cout
);

   always_comb begin
      logic c;
      Sum = '0;
      c   = Cin;
      for (int unsigned i = 0; i < N; i++) begin
         Sum[i] = A[i] ^ B[i] ^ c;
         c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
      end
      Cout = c;
   end

endmodule

module multiword_add_seq #(
   parameter int N     = 8,
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*WORDS-1:0]   A,
   input  logic [N*WORDS-1:0]   B,
   input  logic                 Cin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*WORDS-1:0]   Sum,
   output logic                 Cout
);

   localparam int W  = N * WORDS;
   localparam int CW = $clog2(WORDS) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  opa_q, opa_d;
   logic [W-1:0]  opb_q, opb_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          carry_q, carry_d;
   logic          cout_q, cout_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [N-1:0]  slice_sum;
   logic          slice_cout;
   logic [W-1:0]  sum_shift;

   rca #(.N(N)) u_rca (
      .A    (opa_q[N-1:0]),
      .B    (opb_q[N-1:0]),
      .Cin  (carry_q),
      .Sum  (slice_sum),
      .Cout (slice_cout)
   );

   // Each new slice enters at the top so the low slice ends in place after WORDS shifts.
   generate
      if (WORDS == 1) begin : g_single
         assign sum_shift = slice_sum;
      end else begin : g_multi
         assign sum_shift = {slice_sum, sum_q[W-1:N]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               opa_d   = A;
               opb_d   = B;
               carry_d = Cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d   = sum_shift;
            carry_d = slice_cout;
            opa_d   = opa_q >> N;
            opb_d   = opb_q >> N;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cout_d  = slice_cout;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   // Cout lives in its own register so a new accept (carry_q <= Cin) leaves the last result intact.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign Sum       = sum_q;
   assign Cout      = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq: directed cases on N=8/WORDS=4, random
// traffic on that instance plus WORDS=1 and N=4/WORDS=8 instances.

module tb_multiword_add_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a_bus, b_bus;
   logic        cin;
   logic [2:0]  in_valid, out_ready;
   logic [2:0]  in_ready, out_valid, cout;
   logic        ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2;
   logic [31:0] sum0, sum2;
   logic [7:0]  sum1;

   int total = 0;
   int bad   = 0;
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   multiword_add_seq #(.N(8), .WORDS(4)) u0 (
      .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(ir0),
      .A(a_bus), .B(b_bus), .Cin(cin), .out_valid(ov0), .out_ready(out_ready[0]),
      .Sum(sum0), .Cout(co0)
   );

   multiword_add_seq #(.N(8), .WORDS(1)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(ir1),
      .A(a_bus[7:0]), .B(b_bus[7:0]), .Cin(cin), .out_valid(ov1), .out_ready(out_ready[1]),
      .Sum(sum1), .Cout(co1)
   );

   multiword_add_seq #(.N(4), .WORDS(8)) u2 (
      .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(ir2),
      .A(a_bus), .B(b_bus), .Cin(cin), .out_valid(ov2), .out_ready(out_ready[2]),
      .Sum(sum2), .Cout(co2)
   );

   assign in_ready  = {ir2, ir1, ir0};
   assign out_valid = {ov2, ov1, ov0};
   assign cout      = {co2, co1, co0};

   function automatic logic [31:0] sum_of(input int k);
      case (k)
         0:       return sum0;
         1:       return {24'h0, sum1};
         default: return sum2;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, output bit ok);
      a_bus = a;
      b_bus = b;
      cin   = c;
      in_valid[0] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (in_ready[0]) ok = 1'b1;
         @(negedge clk);
      end
      in_valid[0] = 1'b0;
      if (ok) exp_q.push_back({1'b0, a} + {1'b0, b} + 33'(c));
   endtask

   task automatic recv(output logic [32:0] got, output bit ok);
      out_ready[0] = 1'b1;
      ok  = 1'b0;
      got = 'x;
      for (int i = 0; i < 60 && !ok; i++) begin
         if (out_valid[0]) begin
            got = {cout[0], sum0};
            ok  = 1'b1;
         end
         @(negedge clk);
      end
      out_ready[0] = 1'b0;
   endtask

   task automatic test_reset();
      bit ok;
      logic [32:0] got, e;
      @(negedge clk);
      total++;
      if ({in_ready[0], out_valid[0], cout[0], sum0} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL reset_state: got rdy=%b vld=%b cout=%b sum=%h want 1 0 0 0",
                  in_ready[0], out_valid[0], cout[0], sum0);
      end
      reset = 1'b0;
      @(negedge clk);
      exp_q.delete();
      send(32'h12345678, 32'h00000001, 1'b0, ok);
      total++;
      if (!ok || in_ready[0] !== 1'b0) begin
         bad++;
         $display("FAIL reset_enter_run: got ok=%b rdy=%b want 1 0", ok, in_ready[0]);
      end
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      total++;
      if ({in_ready[0], out_valid[0], cout[0], sum0} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL reset_mid_run: got rdy=%b vld=%b cout=%b sum=%h want 1 0 0 0",
                  in_ready[0], out_valid[0], cout[0], sum0);
      end
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      send(32'h000000FF, 32'h00000001, 1'b0, ok);
      recv(got, ok);
      e = (exp_q.size() != 0) ? exp_q[0] : 'x;
      exp_q.delete();
      total++;
      if (!ok || got !== e) begin
         bad++;
         $display("FAIL reset_next_add: got %h want %h", got, e);
      end
   endtask

   task automatic test_carry_chain();
      bit ok;
      logic [32:0] got, e;
      exp_q.delete();
      send(32'hFFFFFFFF, 32'h00000000, 1'b1, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL carry_accept: got no accept want accept");
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (out_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL carry_early_valid: edge %0d got %b want 0", i, out_valid[0]);
         end
         @(negedge clk);
      end
      total++;
      if (out_valid[0] !== 1'b1) begin
         bad++;
         $display("FAIL carry_latency: got out_valid=%b want 1", out_valid[0]);
      end
      recv(got, ok);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      total++;
      if (!ok || got !== e) begin
         bad++;
         $display("FAIL carry_result: got %h want %h", got, e);
      end
   endtask

   task automatic test_basic();
      bit ok;
      logic [32:0] got, e;
      exp_q.delete();
      send(32'h12345678, 32'h11111111, 1'b0, ok);
      recv(got, ok);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      total++;
      if (!ok || got !== e) begin
         bad++;
         $display("FAIL basic_result: got %h want %h", got, e);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int w;
      logic [32:0] got, e;
      exp_q.delete();
      send(32'hDEADBEEF, 32'h01010101, 1'b1, ok);
      e = (exp_q.size() != 0) ? exp_q[0] : 'x;
      w = 0;
      while (!out_valid[0] && w < 20) begin
         @(negedge clk);
         w++;
      end
      total++;
      if (!out_valid[0]) begin
         bad++;
         $display("FAIL bp_wait: got out_valid=0 want 1");
      end
      a_bus = 32'h11111111;
      b_bus = 32'h22222222;
      in_valid[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if ({cout[0], sum0} !== e || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold: cycle %0d got %h rdy=%b vld=%b want %h 0 1",
                     i, {cout[0], sum0}, in_ready[0], out_valid[0], e);
         end
      end
      in_valid[0] = 1'b0;
      recv(got, ok);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      total++;
      if (!ok || got !== e) begin
         bad++;
         $display("FAIL bp_result: got %h want %h", got, e);
      end
      for (int i = 0; i < 6; i++) begin
         total++;
         if (out_valid[0] !== 1'b0 || {cout[0], sum0} !== e) begin
            bad++;
            $display("FAIL bp_no_extra: cycle %0d got vld=%b res=%h want 0 %h",
                     i, out_valid[0], {cout[0], sum0}, e);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] av[3], bv[3];
      logic        cv[3];
      logic [32:0] ex[3];
      logic [32:0] e;
      int idx, nres, acc_cyc[3];
      bit acc;
      av = '{32'h80000000, 32'hFFFF0000, 32'h00000000};
      bv = '{32'h80000000, 32'h0001FFFF, 32'h00000000};
      cv = '{1'b0, 1'b0, 1'b1};
      ex = '{33'h1_00000000, 33'h1_0000FFFF, 33'h0_00000001};
      exp_q.delete();
      idx = 0; nres = 0; acc = 1'b0;
      acc_cyc = '{0, 0, 0};
      a_bus = av[0]; b_bus = bv[0]; cin = cv[0];
      in_valid[0]  = 1'b1;
      out_ready[0] = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (acc) begin
            acc = 1'b0;
            idx++;
            if (idx < 3) begin
               a_bus = av[idx]; b_bus = bv[idx]; cin = cv[idx];
            end else begin
               in_valid[0] = 1'b0;
            end
         end
         if (in_valid[0] && in_ready[0]) begin
            exp_q.push_back(ex[idx]);
            acc_cyc[idx] = cyc;
            acc = 1'b1;
         end
         if (out_valid[0]) begin
            nres++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            total++;
            if ({cout[0], sum0} !== e) begin
               bad++;
               $display("FAIL b2b_result: #%0d got %h want %h", nres, {cout[0], sum0}, e);
            end
         end
         @(negedge clk);
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b0;
      total++;
      if (nres != 3) begin
         bad++;
         $display("FAIL b2b_count: got %0d results want 3", nres);
      end
      total++;
      if (acc_cyc[1] - acc_cyc[0] != 6) begin
         bad++;
         $display("FAIL b2b_throughput: got %0d cycles between accepts want 6",
                  acc_cyc[1] - acc_cyc[0]);
      end
   endtask

   task automatic test_random(input int k, input int n, input int w);
      logic [32:0] m, r, e, got;
      logic [31:0] mask;
      int done_n, sent, cyc;
      bit acc;
      m = (33'd1 << w) - 33'd1;
      mask = m[31:0];
      exp_q.delete();
      done_n = 0; sent = 0; cyc = 0; acc = 1'b0;
      @(negedge clk);
      while (done_n < n && cyc < n * 40) begin
         if (acc) begin
            in_valid[k] = 1'b0;
            acc = 1'b0;
         end
         if (!in_valid[k] && sent < n && $urandom_range(0, 2) != 0) begin
            a_bus = $urandom & mask;
            b_bus = $urandom & mask;
            cin   = 1'($urandom);
            in_valid[k] = 1'b1;
         end
         out_ready[k] = ($urandom_range(0, 3) != 0);
         total++;
         if (in_ready[k] && out_valid[k]) begin
            bad++;
            $display("FAIL rand_excl: dut %0d got in_ready=1 out_valid=1 want not both", k);
         end
         if (in_valid[k] && in_ready[k]) begin
            r = {1'b0, a_bus} + {1'b0, b_bus} + 33'(cin);
            e = {r[w], r[31:0] & mask};
            exp_q.push_back(e);
            sent++;
            acc = 1'b1;
         end
         if (out_valid[k] && out_ready[k]) begin
            got = {cout[k], sum_of(k)};
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            total++;
            if (got !== e) begin
               bad++;
               $display("FAIL rand_result: dut %0d #%0d got %h want %h", k, done_n, got, e);
            end
            done_n++;
         end
         cyc++;
         @(negedge clk);
      end
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      total++;
      if (done_n != n) begin
         bad++;
         $display("FAIL rand_timeout: dut %0d got %0d results want %0d", k, done_n, n);
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = '0;
      out_ready = '0;
      a_bus     = '0;
      b_bus     = '0;
      cin       = 1'b0;
      test_reset();
      test_carry_chain();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_random(0, 2500, 32);
      test_random(1, 1500, 8);
      test_random(2, 1000, 32);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
